// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl
// Auto-baud controller that owns the divisor of a 16x-oversampling UART baud
// tick generator. Software arms it with `start`. It then times the start bit
// of a host-sent 0x55 sync character on the synchronized RX line and drives
// dvsr = ((low_cycles + 8) >> 4) - 1. A manual load path supports fixed-rate
// operation.
//
// Optional feature, enabled by the macro UART_AUTOBAUD_VERIFY_EN:
//   The high period of data bit 0 is also timed. It must match the low period
//   within (lo >> TOL_SHIFT), otherwise the detection fails.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rx           raw UART RX line (2-FF synchronized internally)
//   start        one-cycle pulse that arms detection (ignored while busy)
//   manual_we    load manual_dvsr into dvsr (IDLE only; start wins)
//   manual_dvsr  manual divisor value
//   dvsr         registered divisor to the baud generator
//   busy         detection in progress
//   locked       dvsr was set by a successful detection
//   err          last detection failed; sticky until start or manual_we
module uart_autobaud_ctrl #(
  parameter int DVSR_W       = 11,
  parameter int CNT_W        = 16,
  parameter int DVSR_DEFAULT = 650,
  parameter int MIN_CNT      = 32,
  parameter int TOL_SHIFT    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  input  logic              manual_we,
  input  logic [DVSR_W-1:0] manual_dvsr,
  output logic [DVSR_W-1:0] dvsr,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WAIT_FALL,
    MEASURE_LO,
`ifdef UART_AUTOBAUD_VERIFY_EN
    MEASURE_HI,
`endif
    CALC
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state, state_nx;
  logic                rx_m, rx_s;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [CNT_W-1:0]    lo, lo_nx;
  logic [DVSR_W-1:0]   dvsr_nx;
  logic                busy_nx, locked_nx, err_nx;
  logic                cnt_sat, glitch, q_fit;
  logic [CNT_W:0]      q;

  // One extra bit of headroom so that lo + 8 cannot wrap. lo >= MIN_CNT >= 8,
  // so the final -1 never underflows.
  assign q       = (({1'b0, lo} + (CNT_W+1)'(8)) >> 4) - (CNT_W+1)'(1);
  assign q_fit   = (q >> DVSR_W) == '0;
  assign cnt_sat = (cnt == CNT_MAX);
  assign glitch  = (cnt < CNT_W'(MIN_CNT));

`ifdef UART_AUTOBAUD_VERIFY_EN
  logic [CNT_W-1:0] hi, hi_nx, diff;
  logic             hi_sat, tol_ok;
  assign hi_sat = (hi == CNT_MAX);
  assign diff   = (hi >= lo) ? hi - lo : lo - hi;
  assign tol_ok = (diff <= (lo >> TOL_SHIFT));
`endif

  // 2-FF synchronizer. It resets to the idle-high line level, so a reset
  // never looks like a falling edge.
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = WAIT_IDLE;
      // A line that is already low at arm time is not measured.
      WAIT_IDLE: if (rx_s)  state_nx = WAIT_FALL;
      WAIT_FALL: if (!rx_s) state_nx = MEASURE_LO;
      MEASURE_LO: begin
        if (!rx_s) begin
          if (cnt_sat) state_nx = IDLE;
        end else if (glitch) begin
          state_nx = WAIT_FALL;
        end else begin
`ifdef UART_AUTOBAUD_VERIFY_EN
          state_nx = MEASURE_HI;
`else
          state_nx = CALC;
`endif
        end
      end
`ifdef UART_AUTOBAUD_VERIFY_EN
      MEASURE_HI: begin
        if (rx_s) begin
          if (hi_sat) state_nx = IDLE;
        end else begin
          state_nx = tol_ok ? CALC : IDLE;
        end
      end
`endif
      CALC:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output and datapath next values. dvsr only moves on a manual load in
  // IDLE or on the CALC edge, so the baud generator sees a single clean step.
  always_comb begin
    dvsr_nx   = dvsr;
    busy_nx   = busy;
    locked_nx = locked;
    err_nx    = err;
    cnt_nx    = cnt;
    lo_nx     = lo;
`ifdef UART_AUTOBAUD_VERIFY_EN
    hi_nx     = hi;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          busy_nx   = 1'b1;
          locked_nx = 1'b0;
          err_nx    = 1'b0;
        end else if (manual_we) begin
          dvsr_nx   = manual_dvsr;
          locked_nx = 1'b0;
          err_nx    = 1'b0;
        end
      end
      WAIT_FALL: if (!rx_s) cnt_nx = CNT_W'(1);
      MEASURE_LO: begin
        if (!rx_s) begin
          if (cnt_sat) begin
            err_nx  = 1'b1;
            busy_nx = 1'b0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end else if (!glitch) begin
          lo_nx = cnt;
`ifdef UART_AUTOBAUD_VERIFY_EN
          hi_nx = CNT_W'(1);
`endif
        end
      end
`ifdef UART_AUTOBAUD_VERIFY_EN
      MEASURE_HI: begin
        if (rx_s) begin
          if (hi_sat) begin
            err_nx  = 1'b1;
            busy_nx = 1'b0;
          end else begin
            hi_nx = hi + CNT_W'(1);
          end
        end else if (!tol_ok) begin
          err_nx  = 1'b1;
          busy_nx = 1'b0;
        end
      end
`endif
      CALC: begin
        busy_nx = 1'b0;
        if (q_fit) begin
          dvsr_nx   = q[DVSR_W-1:0];
          locked_nx = 1'b1;
        end else begin
          err_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr   <= DVSR_W'(DVSR_DEFAULT);
      busy   <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      lo     <= '0;
`ifdef UART_AUTOBAUD_VERIFY_EN
      hi     <= '0;
`endif
    end else begin
      dvsr   <= dvsr_nx;
      busy   <= busy_nx;
      locked <= locked_nx;
      err    <= err_nx;
      cnt    <= cnt_nx;
      lo     <= lo_nx;
`ifdef UART_AUTOBAUD_VERIFY_EN
      hi     <= hi_nx;
`endif
    end
  end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Testbench for uart_autobaud_ctrl. Stimulus tasks drive RX pulse shapes and
// push the expected detection outcome into a scoreboard queue. A monitor pops
// one entry on every busy 1->0 transition and compares the completion cycle,
// dvsr, locked and err. The DUT runs with DVSR_W=10 and CNT_W=15 so that the
// out-of-range and saturation cases stay short. Works in both builds
// (UART_AUTOBAUD_VERIFY_EN defined or not).
module tb_uart_autobaud_ctrl;

  localparam int DVSR_W       = 10;
  localparam int CNT_W        = 15;
  localparam int DVSR_DEFAULT = 650;
  localparam int MIN_CNT      = 32;
  localparam int TOL_SHIFT    = 3;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int DVSR_MAX     = (1 << DVSR_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx;
  logic              start;
  logic              manual_we;
  logic [DVSR_W-1:0] manual_dvsr;
  logic [DVSR_W-1:0] dvsr;
  logic              busy, locked, err;

  uart_autobaud_ctrl #(
    .DVSR_W(DVSR_W), .CNT_W(CNT_W), .DVSR_DEFAULT(DVSR_DEFAULT),
    .MIN_CNT(MIN_CNT), .TOL_SHIFT(TOL_SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .start(start),
    .manual_we(manual_we), .manual_dvsr(manual_dvsr),
    .dvsr(dvsr), .busy(busy), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    int cyc;
    int dvsr;
    int locked;
    int err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_dvsr = DVSR_DEFAULT;
  bit   busy_q   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outcome of a detection whose low period is lo cycles and
  // whose high period is hi cycles, with the low level driven just after
  // clock edge n. RX reaches the FSM 2 cycles late (synchronizer), and the FSM
  // acts 1 cycle after that. A success lands one cycle later (CALC).
  function automatic exp_t predict(input int lo, input int hi, input int n);
    exp_t e;
    int   q;
    e.dvsr   = cur_dvsr;
    e.locked = 0;
    e.err    = 1;
    if (lo > CNT_MAX) begin
      e.cyc = n + 3 + CNT_MAX;
      return e;
    end
`ifdef UART_AUTOBAUD_VERIFY_EN
    if (hi > CNT_MAX) begin
      e.cyc = n + lo + 3 + CNT_MAX;
      return e;
    end
    if (((hi > lo) ? hi - lo : lo - hi) > lo / (1 << TOL_SHIFT)) begin
      e.cyc = n + lo + hi + 3;
      return e;
    end
    e.cyc = n + lo + hi + 4;
`else
    e.cyc = n + lo + 4;
`endif
    q = (lo + 8) / 16 - 1;
    if (q <= DVSR_MAX) begin
      e.dvsr   = q;
      e.locked = 1;
      e.err    = 0;
    end
    return e;
  endfunction

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_busy", int'(busy), 1);
    repeat (4) tick();
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("result_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic pulse(input int lo, input int hi, input bit glitch);
    exp_t e;
    if (glitch) begin
      rx = 1'b0;
      repeat (20) tick();
      rx = 1'b1;
      repeat (10) tick();
      check("glitch_busy", int'(busy), 1);
    end
    e = predict(lo, hi, cycle);
    sb.push_back(e);
    if (e.err == 0) cur_dvsr = e.dvsr;
    rx = 1'b0;
    repeat (lo) tick();
    rx = 1'b1;
`ifdef UART_AUTOBAUD_VERIFY_EN
    repeat (hi) tick();
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
`endif
    repeat (40) tick();
    drain();
  endtask

  task automatic manual_load(input int v);
    manual_dvsr = DVSR_W'(v);
    manual_we   = 1'b1;
    tick();
    manual_we   = 1'b0;
  endtask

  // Monitor: each completed detection (busy falling) is matched against the
  // oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_q = 1'b0;
    end else begin
      if (busy_q && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: busy fell at cycle %0d with nothing expected", cycle);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cycle, e.cyc);
          check("done_dvsr", int'(dvsr), e.dvsr);
          check("done_locked", int'(locked), e.locked);
          check("done_err", int'(err), e.err);
        end
      end
      busy_q = busy;
    end
  end

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 120000", cycle);
    $fatal(1);
  end

  initial begin
    int lo, hi, tol;
    reset       = 1'b1;
    rx          = 1'b1;
    start       = 1'b0;
    manual_we   = 1'b0;
    manual_dvsr = '0;
    repeat (3) tick();
    check("reset_dvsr", int'(dvsr), DVSR_DEFAULT);
    check("reset_busy", int'(busy), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_err", int'(err), 0);
    reset = 1'b0;
    repeat (2) tick();

    // Manual load in IDLE
    manual_load(325);
    cur_dvsr = 325;
    check("manual_dvsr", int'(dvsr), 325);
    check("manual_locked", int'(locked), 0);

    // 9600 baud at 100 MHz
    arm();
    pulse(10417, 10417, 1'b0);
    check("b9600_dvsr", int'(dvsr), 650);

    // 115200 baud preceded by a 20-cycle glitch
    arm();
    pulse(868, 868, 1'b1);
    check("b115200_dvsr", int'(dvsr), 53);

    // Manual load ignored while busy
    arm();
    manual_load(111);
    check("busy_manual_dvsr", int'(dvsr), cur_dvsr);
    check("busy_manual_busy", int'(busy), 1);
    pulse(400, 400, 1'b0);

    // start and manual_we together: start wins
    manual_dvsr = DVSR_W'(222);
    manual_we   = 1'b1;
    start       = 1'b1;
    tick();
    manual_we   = 1'b0;
    start       = 1'b0;
    check("both_dvsr", int'(dvsr), cur_dvsr);
    check("both_busy", int'(busy), 1);
    repeat (4) tick();
    pulse(600, 600, 1'b0);

    // Shortest low period that is not a glitch
    arm();
    pulse(MIN_CNT, MIN_CNT, 1'b0);

    // Just out of range: q = 1024 does not fit in 10 bits
    arm();
    pulse(16392, 16392, 1'b0);
    repeat (5) tick();
    check("err_sticky", int'(err), 1);
    manual_load(325);
    cur_dvsr = 325;
    check("manual_clears_err", int'(err), 0);

`ifdef UART_AUTOBAUD_VERIFY_EN
    // Tolerance limit is 868 >> 3 = 108
    arm();
    pulse(868, 1000, 1'b0);
    arm();
    pulse(868, 976, 1'b0);
`endif

    // Randomized periods, with the high period straddling the tolerance
    for (int i = 0; i < 4; i++) begin
      lo  = int'($urandom_range(MIN_CNT, 400));
      tol = lo / 8;
      hi  = lo - (tol + 3) + int'($urandom_range(0, 2 * tol + 6));
      arm();
      pulse(lo, hi, 1'b0);
    end

    // Counter saturation while the line stays low
    arm();
    pulse(CNT_MAX + 1, 50, 1'b0);

    // Asynchronous reset in the middle of MEASURE_LO
    arm();
    rx = 1'b0;
    repeat (100) tick();
    #3 reset = 1'b1;
    #1;
    check("midreset_dvsr", int'(dvsr), DVSR_DEFAULT);
    check("midreset_busy", int'(busy), 0);
    check("midreset_locked", int'(locked), 0);
    check("midreset_err", int'(err), 0);
    rx = 1'b1;
    repeat (3) tick();
    reset    = 1'b0;
    cur_dvsr = DVSR_DEFAULT;
    repeat (2) tick();

    // Normal detection after reset
    arm();
    pulse(500, 500, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
